elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
Parametrised successor to the single-register, globally stalled inter-stage latch used between pipeline stages. It provides STAGES register slots with per-stage valid bits, a valid/ready handshake, bubble collapsing and synchronous flush. An optional skid slot registers the ready path. Intended drop-in between IF/ID/EX/MEM/WB, letting stages back-pressure individually instead of through one global i_stall.

Parameters:
DATA_W, 32, payload width in bits
STAGES, 1, number of register slots in series (1..8)
SKID, 1, 1 = add skid slot and registered o_ready; 0 = o_ready combinational from i_ready
RESET_VAL, 0, value loaded into every data register on reset
OCC_W, $clog2(STAGES+SKID+1), width of o_occupancy (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
i_valid  input  1  upstream payload valid
o_ready  output  1  block can accept this cycle
i_data  input  DATA_W  upstream payload
i_stall  input  1  global hold, same meaning as existing pipeline stall
i_flush  input  1  synchronous kill of all held entries
o_valid  output  1  downstream payload valid
i_ready  input  1  downstream accepts
o_data  output  DATA_W  payload of last slot
o_occupancy  output  OCC_W  count of valid entries (slots + skid)

Behaviour:
- Reset (rst=0, async): all valid bits 0, all data regs = RESET_VAL, o_valid=0, o_ready=0, o_occupancy=0. First edge after release: o_ready=1.
- Slots s[0..STAGES-1]; s[STAGES-1] drives o_data/o_valid. o_data holds the last value when o_valid=0; it is never forced to 0.
- Acceptance: acc[STAGES-1] = !v[STAGES-1] | i_ready; acc[k] = !v[k] | acc[k+1]. This is bubble collapsing: an empty slot always fills.
- Output transfer: o_valid & i_ready at an edge. Input transfer: i_valid & o_ready at an edge.
- SKID=0: o_ready = acc[0] & !i_stall & !i_flush & rst.
- SKID=1: o_ready = !skid_v & !i_stall & !i_flush, registered (no comb path from i_ready).
  - Input goes to s[0] if acc[0], else to skid.
  - Skid drains into s[0] when acc[0]. Order is strictly FIFO.
- Each cycle, slot k loads s[k-1] (or input/skid for k=0) when acc[k]. It clears its valid bit when it empties without a refill.
- Latency: into an empty block, data accepted at edge N has o_valid=1 after edge N+STAGES-1 (STAGES=1: visible after the accepting edge). Throughput is 1 per cycle with i_ready held 1.
- i_stall=1: no state change, o_valid=0, o_ready=0. Downstream sees no transfer. Held data is preserved.
- i_flush=1: at the next edge all valid bits and skid_v clear and data regs are unchanged. The same-cycle input is not accepted (o_ready=0) and o_valid is forced 0 that cycle. Flush beats stall.
- Simultaneous full-block output transfer and input transfer: both occur and occupancy is unchanged.
- o_occupancy: registered popcount of all valid bits. It is exact every cycle and never exceeds STAGES+SKID.
- Async reset mid-operation discards everything immediately and takes precedence over flush and stall.

Test Plan:
- Streaming: STAGES=3, SKID=1, i_ready=1, inputs 0x11,0x22,0x33,0x44 on consecutive cycles -> o_data shows 0x11..0x44 consecutively, first o_valid 2 cycles after first acceptance, o_occupancy settles at 3.
- Backpressure: STAGES=2, SKID=1, i_ready=0, stream 0xA,0xB,0xC,0xD -> 3 accepted (occupancy 3), o_ready=0. Then i_ready=1 -> outputs 0xA,0xB,0xC in order with no loss or duplication, and o_ready returns to 1 after skid drains.
- Bubble collapse: STAGES=4, single input 0x5 then idle, i_ready=0 -> 0x5 reaches s[3] after 3 edges. Next input 0x6 packs into s[2]. Occupancy 2.
- Flush: occupancy 3, assert i_flush one cycle with i_valid=1, i_data=0x99 -> next cycle occupancy 0, o_valid=0, 0x99 never appears at output.
- Stall: mid-stream i_stall=1 for 4 cycles -> o_valid=0, o_ready=0, occupancy constant. After release, the sequence resumes unchanged.
- Async reset: pull rst low between edges while full -> o_valid, o_ready, o_occupancy go 0 immediately and o_data=RESET_VAL.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: STAGES slots with per-slot valid, valid/ready handshake,
// bubble collapsing, synchronous flush, global stall and an optional skid slot.
module elastic_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  parameter int SKID = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int OCC_W = $clog2(STAGES + SKID + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [OCC_W-1:0]  o_occupancy
);

  logic              run;
  logic              in_xfer;
  logic              out_xfer;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] acc;
  logic [DATA_W-1:0] d_q [STAGES];
  logic              skid_v_q;
  logic              skid_v_d;
  logic [DATA_W-1:0] skid_d_q;
  logic              started_q;
  logic              src_v;
  logic [DATA_W-1:0] src_d;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  assign run         = !i_stall && !i_flush;
  assign o_valid     = v_q[STAGES-1] && run;
  assign o_data      = d_q[STAGES-1];
  assign out_xfer    = o_valid && i_ready;
  assign in_xfer     = i_valid && o_ready;
  assign o_occupancy = occ_q;

  // With a skid slot, o_ready depends only on flops plus stall/flush, never on i_ready.
  assign o_ready = (SKID != 0) ? (started_q && !skid_v_q && run)
                               : (acc[0] && run && rst);

  always_comb begin
    acc = '0;
    acc[STAGES-1] = !v_q[STAGES-1] || out_xfer;
    for (int k = STAGES - 2; k >= 0; k--) begin
      acc[k] = !v_q[k] || acc[k+1];
    end
  end

  // A held skid entry is older than anything on the input, so it feeds slot 0 first.
  always_comb begin
    src_v = in_xfer;
    src_d = i_data;
    if (SKID != 0 && skid_v_q) begin
      src_v = 1'b1;
      src_d = skid_d_q;
    end
  end

  always_comb begin
    v_d      = v_q;
    skid_v_d = skid_v_q;
    if (i_flush) begin
      v_d      = '0;
      skid_v_d = 1'b0;
    end else if (!i_stall) begin
      for (int k = 1; k < STAGES; k++) begin
        if (acc[k]) v_d[k] = v_q[k-1];
      end
      if (acc[0]) v_d[0] = src_v;
      if (SKID != 0) begin
        if (skid_v_q) begin
          if (acc[0]) skid_v_d = 1'b0;
        end else if (in_xfer && !acc[0]) begin
          skid_v_d = 1'b1;
        end
      end
    end
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
    occ_d = occ_d + OCC_W'(skid_v_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q       <= '0;
      skid_v_q  <= 1'b0;
      started_q <= 1'b0;
      occ_q     <= '0;
    end else begin
      v_q       <= v_d;
      skid_v_q  <= skid_v_d;
      started_q <= 1'b1;
      occ_q     <= occ_d;
    end
  end

  // Data only moves with a valid source so o_data keeps its last value when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= RESET_VAL;
      end
      skid_d_q <= RESET_VAL;
    end else if (run) begin
      if (acc[0] && src_v) d_q[0] <= src_d;
      for (int k = 1; k < STAGES; k++) begin
        if (acc[k] && v_q[k-1]) d_q[k] <= d_q[k-1];
      end
      if (SKID != 0 && !skid_v_q && in_xfer && !acc[0]) skid_d_q <= i_data;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: four configurations share stimulus, one is observed at a time
// through a mux; a queue scoreboard checks ordering while tables and sequences check timing.
module tb_elastic_pipe_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_stall, i_flush, i_ready;
  logic [7:0] i_data;
  logic [1:0] sel;

  logic       ov_a, ov_b, ov_c, ov_d;
  logic       rdy_a, rdy_b, rdy_c, rdy_d;
  logic [7:0] od_a, od_b, od_c, od_d;
  logic [2:0] occ_a;
  logic [1:0] occ_b;
  logic [2:0] occ_c;
  logic [0:0] occ_d;

  logic       m_ov, m_or;
  logic [7:0] m_od;
  logic [3:0] m_occ;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb [$];

  typedef struct {
    int stall, flush, valid, data, ready;
    int e_ov, e_or, e_occ, chk_d, e_d;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  elastic_pipe_reg #(.DATA_W(8), .STAGES(3), .SKID(1), .RESET_VAL(8'hE5)) u_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy_a), .i_data(i_data),
    .i_stall(i_stall), .i_flush(i_flush), .o_valid(ov_a), .i_ready(i_ready),
    .o_data(od_a), .o_occupancy(occ_a));
  elastic_pipe_reg #(.DATA_W(8), .STAGES(2), .SKID(1), .RESET_VAL(8'hE5)) u_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy_b), .i_data(i_data),
    .i_stall(i_stall), .i_flush(i_flush), .o_valid(ov_b), .i_ready(i_ready),
    .o_data(od_b), .o_occupancy(occ_b));
  elastic_pipe_reg #(.DATA_W(8), .STAGES(4), .SKID(1), .RESET_VAL(8'hE5)) u_c (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy_c), .i_data(i_data),
    .i_stall(i_stall), .i_flush(i_flush), .o_valid(ov_c), .i_ready(i_ready),
    .o_data(od_c), .o_occupancy(occ_c));
  elastic_pipe_reg #(.DATA_W(8), .STAGES(1), .SKID(0), .RESET_VAL(8'hE5)) u_d (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy_d), .i_data(i_data),
    .i_stall(i_stall), .i_flush(i_flush), .o_valid(ov_d), .i_ready(i_ready),
    .o_data(od_d), .o_occupancy(occ_d));

  always_comb begin
    m_ov = ov_a; m_or = rdy_a; m_od = od_a; m_occ = 4'(occ_a);
    case (sel)
      2'd1: begin m_ov = ov_b; m_or = rdy_b; m_od = od_b; m_occ = 4'(occ_b); end
      2'd2: begin m_ov = ov_c; m_or = rdy_c; m_od = od_c; m_occ = 4'(occ_c); end
      2'd3: begin m_ov = ov_d; m_or = rdy_d; m_od = od_d; m_occ = 4'(occ_d); end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Called while the current cycle's inputs are applied, before the edge that consumes them.
  task automatic sb_update();
    logic [7:0] e;
    if (rst) begin
      if (m_ov && i_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_extra: got output %0h required none", m_od);
        end else begin
          e = sb.pop_front();
          chk("sb_data", int'(m_od), int'(e));
        end
      end
      if (i_flush) sb.delete();
      else if (i_valid && m_or) sb.push_back(i_data);
    end
  endtask

  task automatic cyc(input int v, input int d, input int r, input int s = 0, input int f = 0);
    sb_update();
    @(negedge clk);
    i_valid = 1'(v); i_data = 8'(d); i_ready = 1'(r); i_stall = 1'(s); i_flush = 1'(f);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ov"},  int'(m_ov),  0);
    chk({tag, "_or"},  int'(m_or),  0);
    chk({tag, "_occ"}, int'(m_occ), 0);
    chk({tag, "_od"},  int'(m_od),  'hE5);
  endtask

  task automatic do_reset(input int s);
    sb_update();
    @(negedge clk);
    i_valid = 0; i_data = 0; i_ready = 0; i_stall = 0; i_flush = 0;
    rst = 1'b0;
    sel = 2'(s);
    sb.delete();
    #1;
    chk_reset($sformatf("rst%0d", s));
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input int s, input int f, input int v, input int d, input int r,
                     input int eov, input int eor, input int eocc, input int cd, input int ed);
    vec_t t;
    t.stall = s; t.flush = f; t.valid = v; t.data = d; t.ready = r;
    t.e_ov = eov; t.e_or = eor; t.e_occ = eocc; t.chk_d = cd; t.e_d = ed;
    tbl.push_back(t);
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0;
    i_valid = 0; i_data = 0; i_ready = 0; i_stall = 0; i_flush = 0;
    #2 rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk_reset($sformatf("init%0d", s));
    end

    // STAGES=3 SKID=1: streaming, stall while full, flush with input present
    add(0,0,1,'h11,1, 0,1,0, 1,'hE5);
    add(0,0,1,'h22,1, 0,1,1, 0,0);
    add(0,0,1,'h33,1, 0,1,2, 0,0);
    add(0,0,1,'h44,1, 1,1,3, 1,'h11);
    add(0,0,0,0,   1, 1,1,3, 1,'h22);
    add(0,0,0,0,   1, 1,1,2, 1,'h33);
    add(0,0,0,0,   1, 1,1,1, 1,'h44);
    add(0,0,0,0,   1, 0,1,0, 1,'h44);
    add(0,0,1,'h51,1, 0,1,0, 0,0);
    add(0,0,1,'h52,1, 0,1,1, 0,0);
    add(0,0,1,'h53,1, 0,1,2, 0,0);
    for (int k = 0; k < 4; k++) add(1,0,1,'h54,1, 0,0,3, 1,'h51);
    add(0,0,0,0,   1, 1,1,3, 1,'h51);
    add(0,0,0,0,   1, 1,1,2, 1,'h52);
    add(0,0,0,0,   1, 1,1,1, 1,'h53);
    add(0,0,0,0,   1, 0,1,0, 1,'h53);
    add(0,0,1,'h61,0, 0,1,0, 0,0);
    add(0,0,1,'h62,0, 0,1,1, 0,0);
    add(0,0,1,'h63,0, 0,1,2, 0,0);
    add(0,1,1,'h99,1, 0,0,3, 1,'h61);
    add(0,0,0,0,   1, 0,1,0, 1,'h61);
    add(0,0,1,'h70,1, 0,1,0, 0,0);
    add(0,0,0,0,   1, 0,1,1, 0,0);
    add(0,0,0,0,   1, 0,1,1, 0,0);
    add(0,0,0,0,   1, 1,1,1, 1,'h70);
    add(0,0,0,0,   1, 0,1,0, 1,'h70);

    do_reset(0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].valid, tbl[i].data, tbl[i].ready, tbl[i].stall, tbl[i].flush);
      chk($sformatf("row%0d_ov", i),  int'(m_ov),  tbl[i].e_ov);
      chk($sformatf("row%0d_or", i),  int'(m_or),  tbl[i].e_or);
      chk($sformatf("row%0d_occ", i), int'(m_occ), tbl[i].e_occ);
      if (tbl[i].chk_d != 0) chk($sformatf("row%0d_od", i), int'(m_od), tbl[i].e_d);
    end
    cyc(0,0,0);
    chk("a_sb_empty", sb.size(), 0);

    // STAGES=2 SKID=1: backpressure fills slots plus skid
    do_reset(1);
    cyc(1,'hA,0); chk("bp_or0", int'(m_or), 1);
    cyc(1,'hB,0); chk("bp_or1", int'(m_or), 1);
    cyc(1,'hC,0); chk("bp_or2", int'(m_or), 1);
    cyc(1,'hD,0);
    chk("bp_full_or", int'(m_or), 0);
    chk("bp_full_occ", int'(m_occ), 3);
    chk("bp_full_ov", int'(m_ov), 1);
    chk("bp_full_od", int'(m_od), 'hA);
    cyc(1,'hD,1); chk("bp_rel_or", int'(m_or), 0); chk("bp_rel_occ", int'(m_occ), 3);
    cyc(0,0,1);   chk("bp_drain_or", int'(m_or), 1); chk("bp_drain_occ", int'(m_occ), 2);
    cyc(0,0,1);   chk("bp_drain_occ1", int'(m_occ), 1);
    cyc(0,0,1);   chk("bp_empty_occ", int'(m_occ), 0); chk("bp_empty_ov", int'(m_ov), 0);
    cyc(0,0,0);
    chk("b_sb_empty", sb.size(), 0);

    // STAGES=4 SKID=1: bubble collapse with downstream blocked
    do_reset(2);
    cyc(1,'h5,0); chk("bc_or", int'(m_or), 1);
    cyc(0,0,0); cyc(0,0,0); cyc(0,0,0);
    chk("bc_s2_ov", int'(m_ov), 0); chk("bc_s2_occ", int'(m_occ), 1);
    cyc(1,'h6,0);
    chk("bc_s3_ov", int'(m_ov), 1); chk("bc_s3_od", int'(m_od), 'h5);
    chk("bc_s3_occ", int'(m_occ), 1); chk("bc_s3_or", int'(m_or), 1);
    cyc(0,0,0); cyc(0,0,0); cyc(0,0,0);
    chk("bc_pack_occ", int'(m_occ), 2); chk("bc_pack_od", int'(m_od), 'h5);
    cyc(0,0,0);
    chk("bc_pack_occ_hold", int'(m_occ), 2);
    for (int k = 0; k < 6; k++) cyc(0,0,1);
    chk("bc_drain_occ", int'(m_occ), 0); chk("bc_drain_ov", int'(m_ov), 0);
    cyc(0,0,0);
    chk("c_sb_empty", sb.size(), 0);

    // STAGES=1 SKID=0: combinational ready path and full-rate pass-through
    do_reset(3);
    cyc(1,'hC1,0); chk("nk_or_empty", int'(m_or), 1);
    cyc(1,'hC2,0);
    chk("nk_or_blocked", int'(m_or), 0); chk("nk_ov", int'(m_ov), 1);
    chk("nk_occ", int'(m_occ), 1); chk("nk_od", int'(m_od), 'hC1);
    i_ready = 1'b1;
    #1;
    chk("nk_or_comb", int'(m_or), 1);
    cyc(1,'hC3,1); chk("nk_thru_od", int'(m_od), 'hC2); chk("nk_thru_occ", int'(m_occ), 1);
    cyc(0,0,1);    chk("nk_last_od", int'(m_od), 'hC3);
    cyc(0,0,1);    chk("nk_idle_ov", int'(m_ov), 0); chk("nk_hold_od", int'(m_od), 'hC3);
    cyc(0,0,0);
    chk("d_sb_empty", sb.size(), 0);

    // STAGES=3 SKID=1: async reset between edges while completely full
    do_reset(0);
    cyc(1,'h81,0); cyc(1,'h82,0); cyc(1,'h83,0); cyc(1,'h84,0);
    chk("ar_or_last", int'(m_or), 1);
    cyc(0,0,0);
    chk("ar_full_occ", int'(m_occ), 4); chk("ar_full_ov", int'(m_ov), 1);
    chk("ar_full_or", int'(m_or), 0);   chk("ar_full_od", int'(m_od), 'h81);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    chk_reset("ar_async");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_release_or", int'(m_or), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
